qam_byte_to_sym: RTL and testbench



---
 rtl/qam_byte_to_sym_pkg.sv | 27 ++
 rtl/qam_sync_fifo.sv | 43 ++++
 rtl/qam_byte_to_sym.sv | 102 ++++++++++
 tb/tb_qam_byte_to_sym.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/qam_byte_to_sym_pkg.sv
// parameter_def: shared widths, PRBS7 taps, FIFO word and splitter state types
package parameter_def;
    localparam int SYM_W = 4;
    localparam int PRBS_LEN = 7;
    localparam int PRBS_TAP_A = 6;
    localparam int PRBS_TAP_B = 5;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_word_t;

    typedef enum logic [1:0] {IDLE, FIRST, SECOND} split_state_t;

    // Advance PRBS7 by SYM_W steps; returns {mask, next_state}, first feedback bit in mask MSB
    function automatic logic [SYM_W+PRBS_LEN-1:0] prbs_step(input logic [PRBS_LEN-1:0] s);
        logic [PRBS_LEN-1:0] l;
        logic [SYM_W-1:0] m;
        l = s;
        m = '0;
        for (int i = 0; i < SYM_W; i++) begin
            m[SYM_W-1-i] = l[PRBS_TAP_A] ^ l[PRBS_TAP_B];
            l = {l[PRBS_LEN-2:0], m[SYM_W-1-i]};
        end
        return {m, l};
    endfunction
endpackage

// File: rtl/qam_sync_fifo.sv
// qam_sync_fifo: first-word-fall-through synchronous FIFO with occupancy count
module qam_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;

    // Storage array, written on push only
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    // Pointers and count; simultaneous push/pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rptr];
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/qam_byte_to_sym.sv
// qam_byte_to_sym: byte stream to scrambled 4-bit symbol stream for the 16-QAM modulator
module qam_byte_to_sym
    import parameter_def::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit SCRAMBLE_EN = 1'b1,
    parameter logic [PRBS_LEN-1:0] LFSR_SEED = 7'h7F
) (
    input  logic             axi_clk,
    input  logic             axi_rst,
    input  logic [7:0]       s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic [SYM_W-1:0] m_sym,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [15:0]      sym_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fifo_word_t rd, cur;
    logic full, empty, push, pop, load, load_second, free, acc;
    logic [CW-1:0] cnt;
    logic [SYM_W-1:0] nib, mask;
    logic [PRBS_LEN-1:0] lfsr, lfsr_base, lfsr_adv;
    split_state_t state, state_nxt;

    assign push = s_tvalid && s_tready;

    qam_sync_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(fifo_word_t))) u_fifo (
        .clk(axi_clk),
        .rst(axi_rst),
        .push(push),
        .pop(pop),
        .wdata({s_tlast, s_tdata}),
        .rdata(rd),
        .full(full),
        .empty(empty),
        .count(cnt)
    );

    // Splitter next state, pop/load strobes, nibble select and scrambler step
    always_comb begin
        free = !m_valid || m_ready;
        acc = m_valid && m_ready;
        state_nxt = state;
        pop = 1'b0;
        load_second = 1'b0;
        case (state)
            IDLE: if (free && !empty) begin
                pop = 1'b1;
                state_nxt = FIRST;
            end
            FIRST: if (free) begin
                load_second = 1'b1;
                state_nxt = SECOND;
            end
            SECOND: if (free) begin
                pop = !empty;
                state_nxt = empty ? IDLE : FIRST;
            end
            default: state_nxt = IDLE;
        endcase
        load = pop || load_second;
        nib = pop ? (MSB_FIRST ? rd.data[7:4] : rd.data[3:0])
                  : (MSB_FIRST ? cur.data[3:0] : cur.data[7:4]);
        lfsr_base = (acc && m_last) ? LFSR_SEED : lfsr;
        {mask, lfsr_adv} = prbs_step(lfsr_base);
    end

    // Splitter state register
    always_ff @(posedge axi_clk) begin
        if (axi_rst) state <= IDLE;
        else state <= state_nxt;
    end

    // Output register, held byte, LFSR, symbol counter and registered ready
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            s_tready <= 1'b0;
            cur <= '0;
            lfsr <= LFSR_SEED;
            m_valid <= 1'b0;
            m_last <= 1'b0;
            m_sym <= '0;
            sym_cnt <= '0;
        end else begin
            s_tready <= !(full ? !pop : (push && !pop && cnt == CW'(FIFO_DEPTH - 1)));
            if (pop) cur <= rd;
            lfsr <= load ? lfsr_adv : lfsr_base;
            if (load) begin
                m_sym <= nib ^ (SCRAMBLE_EN ? mask : '0);
                m_last <= load_second && cur.last;
            end
            m_valid <= load || (m_valid && !m_ready);
            if (acc) sym_cnt <= m_last ? 16'd0 : sym_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_qam_byte_to_sym.sv
// tb_qam_byte_to_sym: directed checks of splitting, scrambling, backpressure, framing and reset
module tb_qam_byte_to_sym;
    logic clk = 1'b0;
    logic rst;
    logic [7:0] tdata;
    logic tvalid, tlast, mready;
    logic rdy0, v0, l0, rdy1, v1, l1;
    logic [3:0] sym0, sym1;
    logic [15:0] cnt0, cnt1;
    int total = 0;
    int bad = 0;
    int nv, fi, li;
    logic [3:0] g0 [16];
    logic [3:0] g1 [16];
    logic gl [16];
    logic [3:0] eb1 [8] = '{4'h0, 4'h2, 4'h0, 4'hC, 4'h0, 4'h2, 4'h0, 4'hC};
    logic [3:0] ec0 [10] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
    logic [3:0] ec1 [10] = '{4'h2, 4'h3, 4'h4, 4'hF, 4'h4, 4'hD, 4'h7, 4'h5, 4'h8, 4'h5};
    logic [7:0] bp [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};

    always #5 clk = ~clk;

    qam_byte_to_sym #(.FIFO_DEPTH(4), .MSB_FIRST(1'b1), .SCRAMBLE_EN(1'b0), .LFSR_SEED(7'h7F)) u0 (
        .axi_clk(clk), .axi_rst(rst), .s_tdata(tdata), .s_tvalid(tvalid), .s_tlast(tlast),
        .s_tready(rdy0), .m_sym(sym0), .m_valid(v0), .m_ready(mready), .m_last(l0), .sym_cnt(cnt0)
    );

    qam_byte_to_sym #(.FIFO_DEPTH(4), .MSB_FIRST(1'b0), .SCRAMBLE_EN(1'b1), .LFSR_SEED(7'h7F)) u1 (
        .axi_clk(clk), .axi_rst(rst), .s_tdata(tdata), .s_tvalid(tvalid), .s_tlast(tlast),
        .s_tready(rdy1), .m_sym(sym1), .m_valid(v1), .m_ready(mready), .m_last(l1), .sym_cnt(cnt1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = 8'h00; mready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid0", v0, 0); chk("rst_valid1", v1, 0);
        chk("rst_sym0", sym0, 0); chk("rst_last0", l0, 0);
        chk("rst_cnt0", cnt0, 0); chk("rst_rdy0", rdy0, 0); chk("rst_rdy1", rdy1, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy0", rdy0, 1); chk("post_rst_rdy1", rdy1, 1); chk("post_rst_valid", v0, 0);

        mready = 1'b1; tvalid = 1'b1; tdata = 8'hA5; tlast = 1'b1;
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
        chk("a_n1_valid", v0, 0);
        @(negedge clk);
        chk("a_s0_valid", v0, 1); chk("a_s0_sym0", sym0, 4'hA); chk("a_s0_last0", l0, 0);
        chk("a_s0_sym1", sym1, 4'h5); chk("a_s0_last1", l1, 0); chk("a_s0_cnt", cnt0, 0);
        @(negedge clk);
        chk("a_s1_valid", v0, 1); chk("a_s1_sym0", sym0, 4'h5); chk("a_s1_last0", l0, 1);
        chk("a_s1_sym1", sym1, 4'h8); chk("a_s1_last1", l1, 1); chk("a_s1_cnt", cnt0, 1);
        @(negedge clk);
        chk("a_end_valid", v0, 0); chk("a_end_cnt0", cnt0, 0); chk("a_end_cnt1", cnt1, 0);

        nv = 0; fi = -1; li = -1;
        for (int i = 0; i < 14; i++) begin
            if (v1 && nv < 16) begin
                g0[nv] = sym0; g1[nv] = sym1; gl[nv] = l1;
                if (fi < 0) fi = i;
                li = i;
                nv++;
            end
            tvalid = i < 4; tdata = 8'h00; tlast = (i == 1 || i == 3);
            @(negedge clk);
        end
        chk("b_count", 16'(nv), 8); chk("b_latency", 16'(fi), 2); chk("b_gapfree", 16'(li - fi), 7);
        for (int k = 0; k < 8 && k < nv; k++) begin
            chk($sformatf("b_sym1_%0d", k), g1[k], eb1[k]);
            chk($sformatf("b_sym0_%0d", k), g0[k], 0);
            chk($sformatf("b_last_%0d", k), gl[k], (k == 3 || k == 7) ? 1 : 0);
        end
        chk("b_end_cnt", cnt1, 0);

        mready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("c_rdy_%0d", i), rdy0, 1);
            tvalid = 1'b1; tdata = bp[i]; tlast = (i == 4);
            @(negedge clk);
        end
        tvalid = 1'b0; tlast = 1'b0;
        chk("c_full_rdy0", rdy0, 0); chk("c_full_rdy1", rdy1, 0);
        chk("c_stall_valid", v1, 1); chk("c_stall_sym1", sym1, 4'h2); chk("c_stall_sym0", sym0, 4'h1);
        repeat (3) @(negedge clk);
        chk("c_hold_rdy", rdy0, 0); chk("c_hold_valid", v1, 1);
        chk("c_hold_sym1", sym1, 4'h2); chk("c_hold_sym0", sym0, 4'h1); chk("c_hold_last", l1, 0);
        mready = 1'b1;
        nv = 0; fi = -1; li = -1;
        for (int i = 0; i < 14; i++) begin
            if (v1 && nv < 16) begin
                g0[nv] = sym0; g1[nv] = sym1; gl[nv] = l1;
                if (fi < 0) fi = i;
                li = i;
                nv++;
            end
            @(negedge clk);
        end
        chk("c_count", 16'(nv), 10); chk("c_gapfree", 16'(li - fi), 9);
        for (int k = 0; k < 10 && k < nv; k++) begin
            chk($sformatf("c_sym0_%0d", k), g0[k], ec0[k]);
            chk($sformatf("c_sym1_%0d", k), g1[k], ec1[k]);
            chk($sformatf("c_last_%0d", k), gl[k], (k == 9) ? 1 : 0);
        end
        chk("c_end_rdy", rdy0, 1); chk("c_end_cnt", cnt0, 0);

        mready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tvalid = 1'b1; tdata = 8'h11 * 8'(i + 1); tlast = 1'b0;
            @(negedge clk);
        end
        tvalid = 1'b0; mready = 1'b1;
        @(negedge clk);
        chk("d_pre_cnt", cnt0, 1); chk("d_pre_valid", v0, 1);
        mready = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("d_in_rst_rdy", rdy0, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("d_rst_valid", v0, 0); chk("d_rst_cnt", cnt0, 0); chk("d_rst_last", l1, 0);
        @(negedge clk);
        chk("d_idle_valid", v1, 0); chk("d_idle_rdy", rdy1, 1);
        mready = 1'b1; tvalid = 1'b1; tdata = 8'h00; tlast = 1'b1;
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
        chk("d_n1_valid", v1, 0);
        @(negedge clk);
        chk("d_s0_valid", v1, 1); chk("d_s0_sym1", sym1, 4'h0); chk("d_s0_last", l1, 0);
        @(negedge clk);
        chk("d_s1_sym1", sym1, 4'h2); chk("d_s1_last", l1, 1); chk("d_s1_sym0", sym0, 4'h0);
        @(negedge clk);
        chk("d_end_valid", v1, 0); chk("d_end_cnt", cnt1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
